ahbl_arbiter: RTL and testbench

AHB-lite N:1 arbiter that lets several AHB-lite masters (e.g. per-hart I/D ports) share one downstream slave port or splitter.
- Fixed-priority arbitration; port 0 is highest.
- Each upstream port has a one-entry address-phase buffer, so a master that loses arbitration is stalled and later replayed without dropping its transfer.
- Carries the exclusive-access sideband (hexcl/hmaster/hexokay) and debug sideband (d_pc/hartid) alongside the address phase.

---
 rtl/ahbl_arbiter_pkg.sv | 17 +
 rtl/ahbl_arbiter_reqbuf.sv | 40 ++++
 rtl/onehot_mux.sv | 22 ++
 rtl/ahbl_arbiter.sv | 161 ++++++++++++++++
 tb/tb_ahbl_arbiter.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ahbl_arbiter_pkg.sv
// Shared AHB-lite constants used by the arbiter and its sub-blocks.
//   HTRANS_*     : transfer-type encodings
//   W_HTRANS etc : fixed AHB-lite field widths
package ahbl_arbiter_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam int W_HTRANS = 2;
    localparam int W_HSIZE  = 3;
    localparam int W_HBURST = 3;
    localparam int W_HPROT  = 4;
    localparam int W_HMSTR  = 8;

endpackage

// File: rtl/ahbl_arbiter_reqbuf.sv
// One-entry address-phase buffer for a single upstream port. Holds a losing
// (or stalled) master's address phase until the arbiter replays it.
//   clk, rst_n : clock, async active-low reset
//   cap_i      : capture d_i and mark valid
//   clr_i      : entry issued downstream, mark invalid
//   d_i / q_o  : packed address-phase fields in / held copy out
//   vld_o      : entry holds a pending transfer
module ahbl_arbiter_reqbuf #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cap_i,
    input  logic         clr_i,
    input  logic [W-1:0] d_i,
    output logic         vld_o,
    output logic [W-1:0] q_o
);

    logic         vld_q;
    logic [W-1:0] data_q;

    // cap_i and clr_i never coincide: a buffered port cannot raise a live
    // request because its hready is held low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= 1'b0;
            data_q <= '0;
        end else if (cap_i) begin
            vld_q  <= 1'b1;
            data_q <= d_i;
        end else if (clr_i) begin
            vld_q  <= 1'b0;
        end
    end

    assign vld_o = vld_q;
    assign q_o   = data_q;

endmodule

// File: rtl/onehot_mux.sv
// One-hot select multiplexer: ORs together the inputs whose select bit is
// set. An all-zero select yields all-zero output.
//   sel_i : one-hot select, N bits
//   in_i  : N inputs of W bits
//   out_o : selected value
module onehot_mux #(
    parameter int N = 2,
    parameter int W = 32
) (
    input  logic [N-1:0]        sel_i,
    input  logic [N-1:0][W-1:0] in_i,
    output logic [W-1:0]        out_o
);

    always_comb begin
        out_o = '0;
        for (int i = 0; i < N; i++) begin
            if (sel_i[i]) out_o = out_o | in_i[i];
        end
    end

endmodule

// File: rtl/ahbl_arbiter.sv
// AHB-lite N:1 fixed-priority arbiter (port 0 highest). Each upstream port
// has a one-entry buffer so a losing master is stalled and later replayed.
// Exclusive (hexcl/hmaster/hexokay) and debug (d_pc/hartid) sidebands ride
// along with the address phase. Locked sequences keep the bus on one port.
//   src_* : N_PORTS upstream master ports (packed per port)
//   dst_* : single downstream slave port
module ahbl_arbiter
    import ahbl_arbiter_pkg::*;
#(
    parameter int N_PORTS = 2,
    parameter int W_ADDR  = 32,
    parameter int W_DATA  = 32
) (
    input  logic                             clk,
    input  logic                             rst_n,

    input  logic [N_PORTS-1:0]               src_hready,
    output logic [N_PORTS-1:0]               src_hready_resp,
    output logic [N_PORTS-1:0]               src_hresp,
    input  logic [N_PORTS-1:0][W_ADDR-1:0]   src_haddr,
    input  logic [N_PORTS-1:0]               src_hwrite,
    input  logic [N_PORTS-1:0][W_HTRANS-1:0] src_htrans,
    input  logic [N_PORTS-1:0][W_HSIZE-1:0]  src_hsize,
    input  logic [N_PORTS-1:0][W_HBURST-1:0] src_hburst,
    input  logic [N_PORTS-1:0][W_HPROT-1:0]  src_hprot,
    input  logic [N_PORTS-1:0]               src_hmastlock,
    input  logic [N_PORTS-1:0][W_DATA-1:0]   src_hwdata,
    output logic [N_PORTS-1:0][W_DATA-1:0]   src_hrdata,
    input  logic [N_PORTS-1:0]               src_hexcl,
    input  logic [N_PORTS-1:0][W_HMSTR-1:0]  src_hmaster,
    output logic [N_PORTS-1:0]               src_hexokay,
    input  logic [N_PORTS-1:0][W_ADDR-1:0]   src_d_pc,
    input  logic [N_PORTS-1:0][W_DATA-1:0]   src_hartid,

    output logic                             dst_hready,
    input  logic                             dst_hready_resp,
    input  logic                             dst_hresp,
    output logic [W_ADDR-1:0]                dst_haddr,
    output logic                             dst_hwrite,
    output logic [W_HTRANS-1:0]              dst_htrans,
    output logic [W_HSIZE-1:0]               dst_hsize,
    output logic [W_HBURST-1:0]              dst_hburst,
    output logic [W_HPROT-1:0]               dst_hprot,
    output logic                             dst_hmastlock,
    output logic                             dst_hexcl,
    output logic [W_HMSTR-1:0]               dst_hmaster,
    output logic [W_ADDR-1:0]                dst_d_pc,
    output logic [W_DATA-1:0]                dst_hartid,
    output logic [W_DATA-1:0]                dst_hwdata,
    input  logic [W_DATA-1:0]                dst_hrdata,
    input  logic                             dst_hexokay
);

    localparam int W_REQ = W_ADDR + 1 + W_HTRANS + W_HSIZE + W_HBURST + W_HPROT
                         + 1 + 1 + W_HMSTR + W_ADDR + W_DATA;
    localparam int W_IDX = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

    logic [N_PORTS-1:0][W_REQ-1:0] live_req, buf_req, sel_req;
    logic [N_PORTS-1:0]            buf_valid, req_live, req, cap, clr;
    logic [N_PORTS-1:0]            gnt_a, gnt_d_q, gnt_d_d;
    logic                          lock_hold_q, lock_hold_d, lock_idle;
    logic [W_IDX-1:0]              lock_idx_q, lock_idx_d, gnt_idx;
    logic [W_REQ-1:0]              dst_req;

    for (genvar p = 0; p < N_PORTS; p++) begin : g_port
        assign live_req[p] = {src_haddr[p], src_hwrite[p], src_htrans[p], src_hsize[p],
                              src_hburst[p], src_hprot[p], src_hmastlock[p], src_hexcl[p],
                              src_hmaster[p], src_d_pc[p], src_hartid[p]};
        assign req_live[p] = src_hready[p] && (src_htrans[p] != HTRANS_IDLE) && !buf_valid[p];
        assign req[p]      = buf_valid[p] || req_live[p];
        // Park any live transfer that will not leave on this edge.
        assign cap[p]      = req_live[p] && (!gnt_a[p] || !dst_hready_resp);
        assign clr[p]      = gnt_a[p] && dst_hready_resp;

        ahbl_arbiter_reqbuf #(.W(W_REQ)) u_buf (
            .clk   (clk),
            .rst_n (rst_n),
            .cap_i (cap[p]),
            .clr_i (clr[p]),
            .d_i   (live_req[p]),
            .vld_o (buf_valid[p]),
            .q_o   (buf_req[p])
        );

        assign sel_req[p]         = buf_valid[p] ? buf_req[p] : live_req[p];
        // Stalled ports see hready low from capture until their data phase ends.
        assign src_hready_resp[p] = gnt_d_q[p] ? dst_hready_resp : !buf_valid[p];
        assign src_hresp[p]       = gnt_d_q[p] & dst_hresp;
        assign src_hexokay[p]     = gnt_d_q[p] & dst_hexokay;
    end

    // Descending scan so the lowest-indexed requester wins.
    always_comb begin
        gnt_a   = '0;
        gnt_idx = '0;
        if (lock_hold_q) begin
            gnt_a[lock_idx_q] = req[lock_idx_q];
            gnt_idx           = lock_idx_q;
        end else begin
            for (int i = N_PORTS - 1; i >= 0; i--) begin
                if (req[i]) begin
                    gnt_a    = '0;
                    gnt_a[i] = 1'b1;
                    gnt_idx  = W_IDX'(i);
                end
            end
        end
    end

    onehot_mux #(.N(N_PORTS), .W(W_REQ)) u_amux (
        .sel_i (gnt_a),
        .in_i  (sel_req),
        .out_o (dst_req)
    );

    assign {dst_haddr, dst_hwrite, dst_htrans, dst_hsize, dst_hburst, dst_hprot,
            dst_hmastlock, dst_hexcl, dst_hmaster, dst_d_pc, dst_hartid} = dst_req;
    assign dst_hready = dst_hready_resp;

    onehot_mux #(.N(N_PORTS), .W(W_DATA)) u_wmux (
        .sel_i (gnt_d_q),
        .in_i  (src_hwdata),
        .out_o (dst_hwdata)
    );

    assign src_hrdata = {N_PORTS{dst_hrdata}};

    // The locked master going idle also ends the locked sequence.
    assign lock_idle = src_hready[lock_idx_q] && (src_htrans[lock_idx_q] == HTRANS_IDLE)
                    && !buf_valid[lock_idx_q];

    always_comb begin
        gnt_d_d     = gnt_d_q;
        lock_hold_d = lock_hold_q;
        lock_idx_d  = lock_idx_q;
        if (dst_hready_resp) begin
            gnt_d_d = gnt_a;
            if (|gnt_a) begin
                // Under lock only the locked port can be granted, so this
                // both sets and releases the lock.
                lock_hold_d = dst_hmastlock;
                lock_idx_d  = gnt_idx;
            end else if (lock_hold_q && lock_idle) begin
                lock_hold_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_d_q     <= '0;
            lock_hold_q <= 1'b0;
            lock_idx_q  <= '0;
        end else begin
            gnt_d_q     <= gnt_d_d;
            lock_hold_q <= lock_hold_d;
            lock_idx_q  <= lock_idx_d;
        end
    end

endmodule

// File: tb/tb_ahbl_arbiter.sv
// Directed bench for ahbl_arbiter. Address phases accepted downstream are
// checked against a queue of expected records; per-port responses are
// checked directly against hand-computed values.
module tb_ahbl_arbiter;
    import ahbl_arbiter_pkg::*;

    localparam int N  = 2;
    localparam int WA = 32;
    localparam int WD = 32;

    logic                  clk, rst_n;
    logic [N-1:0]          src_hready, src_hready_resp, src_hresp, src_hwrite;
    logic [N-1:0]          src_hmastlock, src_hexcl, src_hexokay;
    logic [N-1:0][WA-1:0]  src_haddr, src_d_pc;
    logic [N-1:0][1:0]     src_htrans;
    logic [N-1:0][2:0]     src_hsize, src_hburst;
    logic [N-1:0][3:0]     src_hprot;
    logic [N-1:0][WD-1:0]  src_hwdata, src_hrdata, src_hartid;
    logic [N-1:0][7:0]     src_hmaster;
    logic                  dst_hready, dst_hready_resp, dst_hresp, dst_hwrite;
    logic                  dst_hmastlock, dst_hexcl, dst_hexokay;
    logic [WA-1:0]         dst_haddr, dst_d_pc;
    logic [1:0]            dst_htrans;
    logic [2:0]            dst_hsize, dst_hburst;
    logic [3:0]            dst_hprot;
    logic [7:0]            dst_hmaster;
    logic [WD-1:0]         dst_hartid, dst_hwdata, dst_hrdata;

    // True masters: hready is the arbiter's own ready response.
    assign src_hready = src_hready_resp;

    ahbl_arbiter #(.N_PORTS(N), .W_ADDR(WA), .W_DATA(WD)) dut (
        .clk(clk), .rst_n(rst_n),
        .src_hready(src_hready), .src_hready_resp(src_hready_resp), .src_hresp(src_hresp),
        .src_haddr(src_haddr), .src_hwrite(src_hwrite), .src_htrans(src_htrans),
        .src_hsize(src_hsize), .src_hburst(src_hburst), .src_hprot(src_hprot),
        .src_hmastlock(src_hmastlock), .src_hwdata(src_hwdata), .src_hrdata(src_hrdata),
        .src_hexcl(src_hexcl), .src_hmaster(src_hmaster), .src_hexokay(src_hexokay),
        .src_d_pc(src_d_pc), .src_hartid(src_hartid),
        .dst_hready(dst_hready), .dst_hready_resp(dst_hready_resp), .dst_hresp(dst_hresp),
        .dst_haddr(dst_haddr), .dst_hwrite(dst_hwrite), .dst_htrans(dst_htrans),
        .dst_hsize(dst_hsize), .dst_hburst(dst_hburst), .dst_hprot(dst_hprot),
        .dst_hmastlock(dst_hmastlock), .dst_hexcl(dst_hexcl), .dst_hmaster(dst_hmaster),
        .dst_d_pc(dst_d_pc), .dst_hartid(dst_hartid), .dst_hwdata(dst_hwdata),
        .dst_hrdata(dst_hrdata), .dst_hexokay(dst_hexokay)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef logic [WA+1+1+1+8+WA+WD-1:0] rec_t;
    rec_t exp_q[$];
    rec_t mon_got, mon_exp;
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic rec_t mk(input logic [31:0] a, input logic w, input logic lk,
                                input logic ex, input logic [7:0] m, input int p);
        return {a, w, lk, ex, m, a ^ 32'hFFFF_0000, 32'(p)};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input int p, input logic [31:0] a, input logic w, input logic lk,
                       input logic ex, input logic [7:0] m, input bit push);
        src_haddr[p]     = a;
        src_hwrite[p]    = w;
        src_htrans[p]    = HTRANS_NONSEQ;
        src_hsize[p]     = 3'd2;
        src_hburst[p]    = 3'd0;
        src_hprot[p]     = 4'h3;
        src_hmastlock[p] = lk;
        src_hexcl[p]     = ex;
        src_hmaster[p]   = m;
        src_d_pc[p]      = a ^ 32'hFFFF_0000;
        src_hartid[p]    = 32'(p);
        if (push) exp_q.push_back(mk(a, w, lk, ex, m, p));
    endtask

    task automatic idl(input int p);
        src_htrans[p]    = HTRANS_IDLE;
        src_hmastlock[p] = 1'b0;
        src_hexcl[p]     = 1'b0;
    endtask

    // Monitor: every address phase accepted downstream must match the next
    // expected record.
    always @(negedge clk) begin
        if (rst_n && dst_htrans != HTRANS_IDLE && dst_hready_resp) begin
            mon_got = {dst_haddr, dst_hwrite, dst_hmastlock, dst_hexcl, dst_hmaster,
                       dst_d_pc, dst_hartid};
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL addr_phase: unexpected haddr %h, expected none", dst_haddr);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got !== mon_exp) begin
                    n_err++;
                    $display("FAIL addr_phase: got %h expected %h", mon_got, mon_exp);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not reach the end of stimulus");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        src_haddr = '0; src_hwrite = '0; src_htrans = '0; src_hsize = '0;
        src_hburst = '0; src_hprot = '0; src_hmastlock = '0; src_hwdata = '0;
        src_hexcl = '0; src_hmaster = '0; src_d_pc = '0; src_hartid = '0;
        dst_hready_resp = 1'b1; dst_hresp = 1'b0; dst_hrdata = '0; dst_hexokay = 1'b0;

        #3;
        chk("rst_hrdy", src_hready_resp, 2'b11);
        chk("rst_hresp", src_hresp, 2'b00);
        chk("rst_hexokay", src_hexokay, 2'b00);
        chk("rst_htrans", dst_htrans, HTRANS_IDLE);
        repeat (2) step();
        rst_n = 1'b1;
        step();

        // Single master read, no stall
        drv(0, 32'h2000_0000, 1'b0, 1'b0, 1'b0, 8'h01, 1'b1);
        @(negedge clk);
        chk("t1_htrans", dst_htrans, HTRANS_NONSEQ);
        chk("t1_haddr", dst_haddr, 32'h2000_0000);
        chk("t1_hrdy", src_hready_resp, 2'b11);
        step();
        idl(0);
        dst_hrdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("t1_hrdata", src_hrdata[0], 32'hDEAD_BEEF);
        chk("t1_hrdy0", src_hready_resp[0], 1'b1);
        chk("t1_idle", dst_htrans, HTRANS_IDLE);
        step();

        // Simultaneous requests: port 0 wins, port 1 replayed
        drv(0, 32'h1000_0004, 1'b1, 1'b0, 1'b0, 8'h01, 1'b1);
        drv(1, 32'h3000_0010, 1'b0, 1'b0, 1'b0, 8'h02, 1'b1);
        @(negedge clk);
        chk("t2_haddr0", dst_haddr, 32'h1000_0004);
        chk("t2_hrdy_a", src_hready_resp, 2'b11);
        step();
        idl(0); idl(1);
        src_hwdata[0] = 32'hA5A5_0000;
        src_hwdata[1] = 32'h5A5A_FFFF;
        @(negedge clk);
        chk("t2_haddr1", dst_haddr, 32'h3000_0010);
        chk("t2_hrdy_b", src_hready_resp, 2'b01);
        chk("t2_hwdata0", dst_hwdata, 32'hA5A5_0000);
        step();
        @(negedge clk);
        chk("t2_hrdy_c", src_hready_resp, 2'b11);
        chk("t2_hwdata1", dst_hwdata, 32'h5A5A_FFFF);
        chk("t2_idle", dst_htrans, HTRANS_IDLE);
        step();

        // Downstream wait states while port 1 is buffered
        drv(0, 32'h1000_0008, 1'b0, 1'b0, 1'b0, 8'h01, 1'b1);
        @(negedge clk);
        step();
        idl(0);
        drv(1, 32'h3000_0020, 1'b0, 1'b0, 1'b0, 8'h02, 1'b1);
        dst_hready_resp = 1'b0;
        @(negedge clk);
        chk("t3_ws0_addr", dst_haddr, 32'h3000_0020);
        chk("t3_ws0_hrdy", src_hready_resp, 2'b10);
        for (int k = 1; k < 3; k++) begin
            step();
            idl(1);
            @(negedge clk);
            chk("t3_ws_addr", dst_haddr, 32'h3000_0020);
            chk("t3_ws_hrdy", src_hready_resp, 2'b00);
        end
        step();
        dst_hready_resp = 1'b1;
        @(negedge clk);
        chk("t3_issue_addr", dst_haddr, 32'h3000_0020);
        chk("t3_issue_hrdy", src_hready_resp, 2'b01);

        // Two-cycle error response on port 1's data phase
        step();
        dst_hready_resp = 1'b0;
        dst_hresp = 1'b1;
        @(negedge clk);
        chk("t4_hresp_a", src_hresp, 2'b10);
        chk("t4_hrdy_a", src_hready_resp[1], 1'b0);
        step();
        dst_hready_resp = 1'b1;
        @(negedge clk);
        chk("t4_hresp_b", src_hresp, 2'b10);
        chk("t4_hrdy_b", src_hready_resp[1], 1'b1);
        step();
        dst_hresp = 1'b0;

        // Locked sequence on port 1 holds off port 0; exclusive okay
        drv(1, 32'h3000_0100, 1'b1, 1'b1, 1'b1, 8'h02, 1'b1);
        @(negedge clk);
        chk("t5_addr_a", dst_haddr, 32'h3000_0100);
        chk("t5_hresp", src_hresp, 2'b00);
        step();
        drv(1, 32'h3000_0104, 1'b1, 1'b1, 1'b0, 8'h02, 1'b1);
        drv(0, 32'h1000_0010, 1'b0, 1'b0, 1'b0, 8'h01, 1'b0);
        dst_hexokay = 1'b1;
        @(negedge clk);
        chk("t5_hexokay", src_hexokay, 2'b10);
        chk("t5_addr_b", dst_haddr, 32'h3000_0104);
        chk("t5_hrdy_b", src_hready_resp, 2'b11);
        step();
        dst_hexokay = 1'b0;
        idl(0);
        drv(1, 32'h3000_0108, 1'b1, 1'b0, 1'b0, 8'h02, 1'b1);
        @(negedge clk);
        chk("t5_held_addr", dst_haddr, 32'h3000_0108);
        chk("t5_held_hrdy", src_hready_resp, 2'b10);
        chk("t5_hexokay_off", src_hexokay, 2'b00);
        step();
        idl(1);
        exp_q.push_back(mk(32'h1000_0010, 1'b0, 1'b0, 1'b0, 8'h01, 0));
        @(negedge clk);
        chk("t5_release_addr", dst_haddr, 32'h1000_0010);
        chk("t5_release_hrdy", src_hready_resp, 2'b10);
        step();
        @(negedge clk);
        chk("t5_done_hrdy", src_hready_resp, 2'b11);
        step();

        // Reset while port 1 is buffered discards it
        drv(0, 32'h1000_0020, 1'b0, 1'b0, 1'b0, 8'h01, 1'b1);
        drv(1, 32'h3000_0030, 1'b0, 1'b0, 1'b0, 8'h02, 1'b0);
        @(negedge clk);
        step();
        idl(0); idl(1);
        chk("t6_buffered_hrdy", src_hready_resp[1], 1'b0);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_hrdy", src_hready_resp, 2'b11);
        chk("t6_rst_htrans", dst_htrans, HTRANS_IDLE);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_post_htrans", dst_htrans, HTRANS_IDLE);
        chk("t6_post_hrdy", src_hready_resp, 2'b11);
        step();
        @(negedge clk);
        chk("t6_post_htrans2", dst_htrans, HTRANS_IDLE);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
